// File: rtl/acc_dispatcher_queue_pkg.sv
// Shared types for the accelerator dispatcher queue: one buffered accelerator
// request, as it is stored in the queue and presented on the request channel.
package acc_dispatcher_queue_pkg;

    localparam int TransIdBits = 3;
    localparam int XLen        = 64;

    typedef logic [31:0]      instruction_t;
    typedef logic [XLen-1:0]  xlen_t;
    typedef logic [2:0]       roundmode_t;

    typedef struct packed {
        instruction_t           insn;
        xlen_t                  rs1;
        xlen_t                  rs2;
        roundmode_t             frm;
        logic [TransIdBits-1:0] trans_id;
    } acc_disp_entry_t;

endpackage

// File: rtl/acc_dispatcher_queue_if.sv
// Issue, accelerator request/response and writeback channels of the dispatcher.
// Handshakes: a transfer happens on a cycle where valid && ready; once valid is high
// the payload holds until accepted. The response channel is always ready.
interface acc_dispatcher_queue_if #(
    parameter int TransIdBits = acc_dispatcher_queue_pkg::TransIdBits
);
    logic                   issue_valid_i;
    logic                   issue_ready_o;
    logic [31:0]            issue_insn_i;
    logic [63:0]            issue_rs1_i;
    logic [63:0]            issue_rs2_i;
    logic [2:0]             issue_frm_i;
    logic [TransIdBits-1:0] issue_trans_id_i;

    logic                   acc_req_valid_o;
    logic                   acc_req_ready_i;
    logic [31:0]            acc_insn_o;
    logic [63:0]            acc_rs1_o;
    logic [63:0]            acc_rs2_o;
    logic [2:0]             acc_frm_o;
    logic [TransIdBits-1:0] acc_trans_id_o;

    logic                   acc_resp_valid_i;
    logic                   acc_resp_ready_o;
    logic [63:0]            acc_result_i;
    logic [TransIdBits-1:0] acc_resp_trans_id_i;
    logic                   acc_resp_ex_i;

    logic                   wb_valid_o;
    logic [63:0]            wb_result_o;
    logic [TransIdBits-1:0] wb_trans_id_o;
    logic                   wb_ex_o;

    modport slave (
        input  issue_valid_i, issue_insn_i, issue_rs1_i, issue_rs2_i, issue_frm_i,
               issue_trans_id_i, acc_req_ready_i, acc_resp_valid_i, acc_result_i,
               acc_resp_trans_id_i, acc_resp_ex_i,
        output issue_ready_o, acc_req_valid_o, acc_insn_o, acc_rs1_o, acc_rs2_o,
               acc_frm_o, acc_trans_id_o, acc_resp_ready_o, wb_valid_o, wb_result_o,
               wb_trans_id_o, wb_ex_o
    );

    modport master (
        output issue_valid_i, issue_insn_i, issue_rs1_i, issue_rs2_i, issue_frm_i,
               issue_trans_id_i, acc_req_ready_i, acc_resp_valid_i, acc_result_i,
               acc_resp_trans_id_i, acc_resp_ex_i,
        input  issue_ready_o, acc_req_valid_o, acc_insn_o, acc_rs1_o, acc_rs2_o,
               acc_frm_o, acc_trans_id_o, acc_resp_ready_o, wb_valid_o, wb_result_o,
               wb_trans_id_o, wb_ex_o
    );
endinterface

// File: rtl/acc_dispatcher_queue_resp_reg.sv
// Registered writeback stage: one accelerator response becomes a single-cycle
// writeback pulse on the following cycle.
module acc_dispatcher_queue_resp_reg
    import acc_dispatcher_queue_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   i_valid,
    input  logic [63:0]            i_result,
    input  logic [TransIdBits-1:0] i_trans_id,
    input  logic                   i_ex,
    output logic                   o_valid,
    output logic [63:0]            o_result,
    output logic [TransIdBits-1:0] o_trans_id,
    output logic                   o_ex
);
    logic                   r_valid;
    logic [63:0]            r_result;
    logic [TransIdBits-1:0] r_trans_id;
    logic                   r_ex;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_valid    <= 1'b0;
            r_result   <= '0;
            r_trans_id <= '0;
            r_ex       <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_result   <= i_result;
                r_trans_id <= i_trans_id;
                r_ex       <= i_ex;
            end
        end
    end

    assign o_valid    = r_valid;
    assign o_result   = r_result;
    assign o_trans_id = r_trans_id;
    assign o_ex       = r_ex;
endmodule

// File: rtl/acc_dispatcher_queue.sv
// Holds speculatively issued accelerator instructions and releases them to the
// accelerator only once committed; accelerator responses are registered to writeback.
module acc_dispatcher_queue
    import acc_dispatcher_queue_pkg::*;
#(
    parameter int NrEntries   = 4,
    parameter int MaxInflight = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               flush_i,
    input  logic                               commit_i,
    acc_dispatcher_queue_if.slave              bus,
    output logic [$clog2(MaxInflight+1)-1:0]   inflight_o,
    output logic                               idle_o
);
    localparam int IdxW = $clog2(NrEntries);
    localparam int PtrW = IdxW + 1;
    localparam int CntW = $clog2(MaxInflight + 1);

    typedef logic [PtrW-1:0] ptr_t;

    // Ring order is is_ptr <= cm_ptr <= wr_ptr; the extra MSB tells full from empty.
    acc_disp_entry_t r_mem [NrEntries];
    ptr_t            r_wr_ptr;
    ptr_t            r_cm_ptr;
    ptr_t            r_is_ptr;
    logic [CntW-1:0] r_inflight;

    ptr_t            w_occupancy;
    ptr_t            w_uncommitted;
    ptr_t            w_cm_next;
    ptr_t            w_wr_next;
    logic            w_enq;
    logic            w_commit;
    logic            w_req_valid;
    logic            w_req_hs;
    logic            w_resp_dec;
    acc_disp_entry_t w_head;
    acc_disp_entry_t w_new_entry;

    assign w_occupancy   = r_wr_ptr - r_is_ptr;
    assign w_uncommitted = r_wr_ptr - r_cm_ptr;

    assign bus.issue_ready_o = (w_occupancy < ptr_t'(NrEntries)) && !flush_i;
    assign w_enq             = bus.issue_valid_i && bus.issue_ready_o;
    assign w_commit          = commit_i && (w_uncommitted != '0);
    assign w_cm_next         = r_cm_ptr + ptr_t'(w_commit);

    assign w_new_entry.insn     = bus.issue_insn_i;
    assign w_new_entry.rs1      = bus.issue_rs1_i;
    assign w_new_entry.rs2      = bus.issue_rs2_i;
    assign w_new_entry.frm      = bus.issue_frm_i;
    assign w_new_entry.trans_id = bus.issue_trans_id_i;

    // A flush rewinds the write pointer onto the (post-commit) commit pointer.
    always_comb begin
        w_wr_next = r_wr_ptr;
        if (flush_i) begin
            w_wr_next = w_cm_next;
        end else if (w_enq) begin
            w_wr_next = r_wr_ptr + ptr_t'(1);
        end
    end

    assign w_head      = r_mem[r_is_ptr[IdxW-1:0]];
    assign w_req_valid = (r_cm_ptr != r_is_ptr) && (r_inflight < CntW'(MaxInflight));
    assign w_req_hs    = w_req_valid && bus.acc_req_ready_i;
    assign w_resp_dec  = bus.acc_resp_valid_i && (r_inflight != '0);

    assign bus.acc_req_valid_o  = w_req_valid;
    assign bus.acc_insn_o       = w_head.insn;
    assign bus.acc_rs1_o        = w_head.rs1;
    assign bus.acc_rs2_o        = w_head.rs2;
    assign bus.acc_frm_o        = w_head.frm;
    assign bus.acc_trans_id_o   = w_head.trans_id;
    assign bus.acc_resp_ready_o = 1'b1;

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wr_ptr[IdxW-1:0]] <= w_new_entry;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_cm_ptr <= '0;
            r_is_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_cm_ptr <= w_cm_next;
            if (w_req_hs) begin
                r_is_ptr <= r_is_ptr + ptr_t'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_inflight <= '0;
        end else if (w_req_hs && !w_resp_dec) begin
            r_inflight <= r_inflight + CntW'(1);
        end else if (!w_req_hs && w_resp_dec) begin
            r_inflight <= r_inflight - CntW'(1);
        end
    end

    acc_dispatcher_queue_resp_reg u_resp_reg (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_valid    (bus.acc_resp_valid_i),
        .i_result   (bus.acc_result_i),
        .i_trans_id (bus.acc_resp_trans_id_i),
        .i_ex       (bus.acc_resp_ex_i),
        .o_valid    (bus.wb_valid_o),
        .o_result   (bus.wb_result_o),
        .o_trans_id (bus.wb_trans_id_o),
        .o_ex       (bus.wb_ex_o)
    );

    assign inflight_o = r_inflight;
    assign idle_o     = (w_occupancy == '0) && (r_inflight == '0);

`ifndef SYNTHESIS
    a_no_orphan_resp : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(bus.acc_resp_valid_i && (r_inflight == '0)))
        else $error("accelerator response with no request outstanding");
`endif
endmodule

// File: tb/tb_acc_dispatcher_queue.sv
// Bench for acc_dispatcher_queue: directed scenarios plus random traffic, checked
// against a queue-based model of uncommitted/committed work and outstanding requests.
module tb_acc_dispatcher_queue;
    import acc_dispatcher_queue_pkg::*;

    localparam int NR   = 4;
    localparam int MAXI = 8;
    localparam int CNTW = $clog2(MAXI + 1);
    localparam int WBW  = 1 + TransIdBits + 64;

    logic            clk_i    = 1'b0;
    logic            rst_ni   = 1'b0;
    logic            flush_i  = 1'b0;
    logic            commit_i = 1'b0;
    logic [CNTW-1:0] inflight_o;
    logic            idle_o;

    acc_dispatcher_queue_if #(.TransIdBits(TransIdBits)) bus ();

    acc_dispatcher_queue #(.NrEntries(NR), .MaxInflight(MAXI)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .commit_i   (commit_i),
        .bus        (bus.slave),
        .inflight_o (inflight_o),
        .idle_o     (idle_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors    = 0;
    int miscompares = 0;
    int dut_hs     = 0;
    bit checks_en  = 1'b0;

    acc_disp_entry_t m_unc[$];
    acc_disp_entry_t m_com[$];
    int              m_inflight = 0;
    logic [WBW-1:0]  exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit p_req_valid();
        return (m_com.size() > 0) && (m_inflight < MAXI);
    endfunction

    function automatic bit p_issue_ready();
        return ((m_unc.size() + m_com.size()) < NR) && !flush_i;
    endfunction

    // Reference model: advances on each clock edge from the inputs of that cycle.
    always @(posedge clk_i) begin : model
        bit hs;
        bit rdy;
        bit dec;
        acc_disp_entry_t e;
        if (!rst_ni) begin
            m_unc.delete();
            m_com.delete();
            m_inflight = 0;
            exp_q.delete();
        end else begin
            hs  = p_req_valid() && bus.acc_req_ready_i;
            rdy = p_issue_ready();
            if (hs) void'(m_com.pop_front());
            if (commit_i && m_unc.size() > 0) m_com.push_back(m_unc.pop_front());
            if (flush_i) m_unc.delete();
            if (bus.issue_valid_i && rdy) begin
                e.insn     = bus.issue_insn_i;
                e.rs1      = bus.issue_rs1_i;
                e.rs2      = bus.issue_rs2_i;
                e.frm      = bus.issue_frm_i;
                e.trans_id = bus.issue_trans_id_i;
                m_unc.push_back(e);
            end
            dec = bus.acc_resp_valid_i && (m_inflight > 0);
            m_inflight = m_inflight + int'(hs) - int'(dec);
            if (bus.acc_resp_valid_i)
                exp_q.push_back({bus.acc_resp_ex_i, bus.acc_resp_trans_id_i, bus.acc_result_i});
        end
    end

    // Monitor: compares DUT outputs with the model mid-cycle.
    always @(negedge clk_i) begin : monitor
        logic [WBW-1:0] w;
        bit exp_wb;
        if (checks_en) begin
            if (bus.acc_req_valid_o && bus.acc_req_ready_i) dut_hs++;
            check("req_valid", 64'(bus.acc_req_valid_o), 64'(p_req_valid()));
            if (p_req_valid()) begin
                check("req_insn", 64'(bus.acc_insn_o), 64'(m_com[0].insn));
                check("req_rs1", bus.acc_rs1_o, m_com[0].rs1);
                check("req_rs2", bus.acc_rs2_o, m_com[0].rs2);
                check("req_frm", 64'(bus.acc_frm_o), 64'(m_com[0].frm));
                check("req_id", 64'(bus.acc_trans_id_o), 64'(m_com[0].trans_id));
            end
            check("issue_ready", 64'(bus.issue_ready_o), 64'(p_issue_ready()));
            check("inflight", 64'(inflight_o), 64'(m_inflight));
            check("idle", 64'(idle_o),
                  64'((m_unc.size() + m_com.size() == 0) && (m_inflight == 0)));
            check("resp_ready", 64'(bus.acc_resp_ready_o), 64'(1));
            exp_wb = exp_q.size() > 0;
            check("wb_valid", 64'(bus.wb_valid_o), 64'(exp_wb));
            if (exp_wb) begin
                w = exp_q.pop_front();
                if (bus.wb_valid_o) begin
                    check("wb_result", bus.wb_result_o, w[63:0]);
                    check("wb_id", 64'(bus.wb_trans_id_o), 64'(w[64 +: TransIdBits]));
                    check("wb_ex", 64'(bus.wb_ex_o), 64'(w[WBW-1]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic idle_inputs();
        bus.issue_valid_i    = 1'b0;
        bus.acc_resp_valid_i = 1'b0;
        commit_i             = 1'b0;
        flush_i              = 1'b0;
    endtask

    task automatic set_issue(input logic [31:0] insn, input logic [TransIdBits-1:0] id);
        bus.issue_insn_i     = insn;
        bus.issue_rs1_i      = {$urandom, $urandom};
        bus.issue_rs2_i      = {$urandom, $urandom};
        bus.issue_frm_i      = 3'($urandom_range(0, 7));
        bus.issue_trans_id_i = id;
    endtask

    task automatic enqueue(input logic [31:0] insn, input logic [TransIdBits-1:0] id);
        set_issue(insn, id);
        bus.issue_valid_i = 1'b1;
        tick();
        bus.issue_valid_i = 1'b0;
    endtask

    task automatic commit_one();
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
    endtask

    task automatic respond(input logic [63:0] res, input logic [TransIdBits-1:0] id, input logic ex);
        bus.acc_resp_valid_i    = 1'b1;
        bus.acc_result_i        = res;
        bus.acc_resp_trans_id_i = id;
        bus.acc_resp_ex_i       = ex;
        tick();
        bus.acc_resp_valid_i = 1'b0;
    endtask

    task automatic respond_all();
        for (int k = 0; k < 24 && (m_inflight > 0 || m_com.size() > 0); k++) begin
            if (m_inflight > 0)
                respond({$urandom, $urandom}, TransIdBits'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            else
                tick();
        end
        wait_cycles(2);
    endtask

    initial begin
        int base;
        idle_inputs();
        bus.acc_req_ready_i     = 1'b0;
        bus.acc_result_i        = '0;
        bus.acc_resp_trans_id_i = '0;
        bus.acc_resp_ex_i       = 1'b0;
        set_issue(32'h0, '0);
        rst_ni = 1'b0;
        wait_cycles(2);
        rst_ni    = 1'b1;
        checks_en = 1'b1;
        check("rst_idle", 64'(idle_o), 64'(1));
        check("rst_ready", 64'(bus.issue_ready_o), 64'(1));

        // Held until committed, then issued.
        bus.acc_req_ready_i = 1'b1;
        enqueue(32'h0000_0057, 3'd2);
        wait_cycles(10);
        commit_one();
        wait_cycles(2);
        check("t1_inflight", 64'(inflight_o), 64'(1));
        respond_all();

        // Fill, reject a fifth, drain in order; repeated to wrap the pointers.
        for (int rep = 0; rep < 3; rep++) begin
            bus.acc_req_ready_i = 1'b0;
            for (int i = 0; i < 4; i++) enqueue($urandom, TransIdBits'(i));
            check("t2_full", 64'(bus.issue_ready_o), 64'(0));
            enqueue($urandom, 3'd4);
            for (int i = 0; i < 4; i++) commit_one();
            bus.acc_req_ready_i = 1'b1;
            wait_cycles(6);
            respond_all();
        end

        // Flush alongside a commit keeps the committed entries.
        bus.acc_req_ready_i = 1'b0;
        enqueue(32'h11, 3'd1);
        enqueue(32'h22, 3'd2);
        enqueue(32'h33, 3'd3);
        commit_one();
        commit_i = 1'b1;
        flush_i  = 1'b1;
        #1;
        check("t3_flush_ready", 64'(bus.issue_ready_o), 64'(0));
        tick();
        idle_inputs();
        bus.acc_req_ready_i = 1'b1;
        base = dut_hs;
        wait_cycles(5);
        check("t3_issued", 64'(dut_hs - base), 64'(2));
        respond_all();
        check("t3_idle", 64'(idle_o), 64'(1));

        // Inflight limit.
        bus.acc_req_ready_i = 1'b1;
        base = dut_hs;
        for (int i = 0; i < 9; i++) begin
            enqueue($urandom, TransIdBits'(i));
            commit_one();
        end
        wait_cycles(4);
        check("t4_handshakes", 64'(dut_hs - base), 64'(8));
        check("t4_inflight", 64'(inflight_o), 64'(8));
        check("t4_stall", 64'(bus.acc_req_valid_o), 64'(0));
        respond(64'h1, 3'd0, 1'b0);
        wait_cycles(2);
        check("t4_ninth", 64'(dut_hs - base), 64'(9));
        respond_all();

        // Issue handshake and response in the same cycle.
        bus.acc_req_ready_i = 1'b0;
        enqueue(32'hA1, 3'd6);
        commit_one();
        enqueue(32'hA2, 3'd7);
        commit_one();
        bus.acc_req_ready_i = 1'b1;
        tick();
        respond(64'hDEAD, 3'd5, 1'b1);
        bus.acc_req_ready_i = 1'b0;
        check("t5_inflight", 64'(inflight_o), 64'(2 - 1));
        check("t5_wb_valid", 64'(bus.wb_valid_o), 64'(1));
        check("t5_wb_result", bus.wb_result_o, 64'hDEAD);
        check("t5_wb_id", 64'(bus.wb_trans_id_o), 64'(5));
        check("t5_wb_ex", 64'(bus.wb_ex_o), 64'(1));
        bus.acc_req_ready_i = 1'b1;
        respond_all();

        // Reset mid-operation.
        bus.acc_req_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) enqueue($urandom, TransIdBits'(i));
        for (int i = 0; i < 3; i++) commit_one();
        bus.acc_req_ready_i = 1'b1;
        wait_cycles(3);
        bus.acc_req_ready_i = 1'b0;
        enqueue($urandom, 3'd3);
        enqueue($urandom, 3'd4);
        commit_one();
        commit_one();
        check("t6_pre_inflight", 64'(inflight_o), 64'(3));
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        check("t6_inflight", 64'(inflight_o), 64'(0));
        check("t6_idle", 64'(idle_o), 64'(1));
        check("t6_req_valid", 64'(bus.acc_req_valid_o), 64'(0));
        check("t6_wb_valid", 64'(bus.wb_valid_o), 64'(0));
        check("t6_wb_result", bus.wb_result_o, 64'(0));
        check("t6_wb_id", 64'(bus.wb_trans_id_o), 64'(0));
        check("t6_wb_ex", 64'(bus.wb_ex_o), 64'(0));
        check("t6_ready", 64'(bus.issue_ready_o), 64'(1));

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            set_issue($urandom, TransIdBits'($urandom_range(0, 7)));
            bus.issue_valid_i       = 1'($urandom_range(0, 1));
            commit_i                = ($urandom_range(0, 2) == 0);
            flush_i                 = ($urandom_range(0, 15) == 0);
            bus.acc_req_ready_i     = ($urandom_range(0, 3) != 0);
            bus.acc_resp_valid_i    = (m_inflight > 0) && ($urandom_range(0, 2) == 0);
            bus.acc_result_i        = {$urandom, $urandom};
            bus.acc_resp_trans_id_i = TransIdBits'($urandom_range(0, 7));
            bus.acc_resp_ex_i       = 1'($urandom_range(0, 1));
            tick();
        end
        idle_inputs();
        bus.acc_req_ready_i = 1'b1;
        respond_all();
        respond_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
